// File: rtl/sipo_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver.
//   rx_state_t  : receiver FSM state encoding
//   START_LEVEL : line level that marks a start bit
//   STOP_LEVEL  : line level required in the stop-bit slot
//   IDLE_LEVEL  : resting level of the serial line
// SIPO_RX_PARITY_EN (optional macro) enables the PARITY state in the top level.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/sipo_frame_receiver_if.sv
// Parallel word handshake between the frame receiver and its consumer.
//   rx_data  : received word, stable while rx_valid is high
//   rx_valid : word available
//   rx_ready : consumer accepts the word when rx_valid && rx_ready at a rising edge
// master = receiver side, slave = consumer side.
interface sipo_frame_receiver_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/sipo_frame_receiver_shift_core.sv
// rx_shift_core: data shift register plus bit counter for the frame receiver.
//   clk, rst  : clock and synchronous active-high reset
//   clr       : zero register and counter (frame start)
//   shift_en  : shift bit_in in and advance the counter
//   bit_in    : serial sample
//   data      : assembled word
//   cnt_done  : high while the current shift is the last data bit of the word
// MSB_FIRST=0 places the first received bit in data[0]; MSB_FIRST=1 in data[DATA_W-1].
// DATA_W must be at least 2.
module rx_shift_core #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data,
    output logic              cnt_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_next;

    always_comb begin
        data_next = data;
        if (MSB_FIRST != 0) begin
            data_next = {data[DATA_W-2:0], bit_in};
        end else begin
            data_next = {bit_in, data[DATA_W-1:1]};
        end
    end

    // Flag the final shift so the FSM leaves DATA on that same edge.
    assign cnt_done = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            data <= data_next;
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: samples a serial line once per clock, recognises
// start(0) / DATA_W data bits / [even parity] / stop(1) frames and presents
// each good word on a valid/ready output register.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   s_in       : serial line, idles high
//   rx_if      : master side of rx_data / rx_valid / rx_ready
//   frame_err  : one-cycle pulse when the stop slot sampled 0
//   parity_err : one-cycle pulse on parity mismatch (0 without the parity option)
//   overrun    : sticky; a good word was dropped because the previous one was unread
//   busy       : FSM not in IDLE
// Optional macro SIPO_RX_PARITY_EN adds one even-parity bit after the data.
module sipo_frame_receiver
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    sipo_frame_receiver_if.master rx_if,
    output logic frame_err,
    output logic parity_err,
    output logic overrun,
    output logic busy
);

    rx_state_t         state;
    logic [DATA_W-1:0] shift_data;
    logic              cnt_done;
    logic              shift_en;
    logic              frame_start;
    logic              par_bad;
    logic              good_word;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign shift_en    = (state == DATA);
    assign frame_start = (state == IDLE) && (s_in == START_LEVEL);

    rx_shift_core #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (reset),
        .clr      (frame_start),
        .shift_en (shift_en),
        .bit_in   (s_in),
        .data     (shift_data),
        .cnt_done (cnt_done)
    );

`ifndef SIPO_RX_PARITY_EN
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A word is good only when the stop slot is high and parity (if any) matched.
    assign good_word = (state == STOP) && (s_in == STOP_LEVEL) && !par_bad;

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses unless re-armed below.
            frame_err  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s_in == START_LEVEL) begin
                        state <= DATA;
                        busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_done) begin
`ifdef SIPO_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_bad <= (s_in != (^shift_data));
                    state   <= STOP;
                end
`endif
                STOP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    frame_err <= (s_in != STOP_LEVEL);
`ifdef SIPO_RX_PARITY_EN
                    parity_err <= par_bad;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Output register: a same-edge handshake frees the slot for the new word.
            if (good_word) begin
                if (!valid_q || rx_if.rx_ready) begin
                    data_q  <= shift_data;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Self-checking bench for sipo_frame_receiver (DATA_W=8, MSB_FIRST=0).
// Words expected at the consumer are queued when their frames are driven and
// popped whenever a handshake is observed. Build with +define+SIPO_RX_PARITY_EN
// to exercise the parity option.
module tb_sipo_frame_receiver;

    localparam int DATA_W = 8;
`ifdef SIPO_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pflip;
        logic       exp_ferr;
        logic       exp_perr;
        logic       exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic s_in;
    logic frame_err;
    logic parity_err;
    logic overrun;
    logic busy;

    sipo_frame_receiver_if #(.DATA_W(DATA_W)) rx_if ();

    sipo_frame_receiver #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_in       (s_in),
        .rx_if      (rx_if),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb_q[$];
    vec_t       vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // One clock: handshake check on the falling edge, inputs settle 1 after the rising edge.
    task automatic step();
        logic [7:0] exp_w;
        @(negedge clk);
        if (!reset && rx_if.rx_valid && rx_if.rx_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got word %0h, required no word", rx_if.rx_data);
            end else begin
                exp_w = sb_q.pop_front();
                chk("sb_word", 32'(rx_if.rx_data), 32'(exp_w));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_in  = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Drives a full frame; returns 1 time unit after the stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                              input logic rdy_at_stop);
        s_in = 1'b0;
        step();
        for (int i = 0; i < DATA_W; i++) begin
            s_in = d[i];
            step();
        end
`ifdef SIPO_RX_PARITY_EN
        s_in = (^d) ^ pflip;
        step();
`endif
        if (rdy_at_stop) rx_if.rx_ready = 1'b1;
        s_in = stop;
        step();
        s_in = 1'b1;
    endtask

    initial begin
        logic [15:0] fr;
        int          nbits;
        int          first_valid;

        vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
`ifdef SIPO_RX_PARITY_EN
        vecs.push_back('{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
`endif

        rx_if.rx_ready = 1'b1;
        do_reset();
        chk("reset_rx_data", 32'(rx_if.rx_data), 32'h0);
        chk("reset_rx_valid", 32'(rx_if.rx_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_parity_err", 32'(parity_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        // Latency of a single 0xA5 frame, counted in edges from the start bit.
        step();
        nbits = DATA_W + 2 + PAR_BITS;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = 8'hA5;
        if (PAR_BITS == 1) fr[9] = ^fr[8:1];
        sb_q.push_back(8'hA5);
        first_valid = 0;
        for (int i = 0; i < nbits; i++) begin
            s_in = fr[i];
            step();
            if (i == 0) chk("t1_busy_after_start", 32'(busy), 32'h1);
            if (rx_if.rx_valid && first_valid == 0) first_valid = i + 1;
        end
        s_in = 1'b1;
        chk("t1_latency", 32'(first_valid), 32'(DATA_W + 2 + PAR_BITS));
        chk("t1_rx_data", 32'(rx_if.rx_data), 32'hA5);
        chk("t1_frame_err", 32'(frame_err), 32'h0);
        step();
        chk("t1_valid_pulse", 32'(rx_if.rx_valid), 32'h0);

        // Table of single frames with rx_ready held high.
        foreach (vecs[k]) begin
            if (vecs[k].exp_word) sb_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].pflip, 1'b0);
            chk($sformatf("v%0d_frame_err", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
            chk($sformatf("v%0d_parity_err", k), 32'(parity_err), 32'(vecs[k].exp_perr));
            chk($sformatf("v%0d_rx_valid", k), 32'(rx_if.rx_valid), 32'(vecs[k].exp_word));
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'h0);
            if (vecs[k].exp_word)
                chk($sformatf("v%0d_rx_data", k), 32'(rx_if.rx_data), 32'(vecs[k].data));
            step();
            chk($sformatf("v%0d_ferr_cleared", k), 32'(frame_err), 32'h0);
            chk($sformatf("v%0d_perr_cleared", k), 32'(parity_err), 32'h0);
            chk($sformatf("v%0d_valid_after", k), 32'(rx_if.rx_valid), 32'h0);
        end
        chk("tbl_overrun", 32'(overrun), 32'h0);

        // Overrun: back-to-back frames with the consumer stalled.
        do_reset();
        rx_if.rx_ready = 1'b0;
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        chk("t3_rx_data", 32'(rx_if.rx_data), 32'h3C);
        chk("t3_rx_valid", 32'(rx_if.rx_valid), 32'h1);
        chk("t3_overrun", 32'(overrun), 32'h1);
        rx_if.rx_ready = 1'b1;
        step();
        chk("t3_valid_drop", 32'(rx_if.rx_valid), 32'h0);
        chk("t3_overrun_sticky", 32'(overrun), 32'h1);

        // Handshake on the same edge a new word completes.
        do_reset();
        rx_if.rx_ready = 1'b0;
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        chk("t4_hold_valid", 32'(rx_if.rx_valid), 32'h1);
        chk("t4_hold_data", 32'(rx_if.rx_data), 32'h11);
        sb_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b0, 1'b1);
        chk("t4_rx_data", 32'(rx_if.rx_data), 32'h22);
        chk("t4_rx_valid", 32'(rx_if.rx_valid), 32'h1);
        chk("t4_overrun", 32'(overrun), 32'h0);
        step();
        chk("t4_valid_after", 32'(rx_if.rx_valid), 32'h0);

        // Reset in the middle of a 0xFF frame, then a clean 0x5A frame.
        rx_if.rx_ready = 1'b1;
        s_in = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            s_in = 1'b1;
            step();
        end
        reset = 1'b1;
        s_in  = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rx_data", 32'(rx_if.rx_data), 32'h0);
        chk("t5_rx_valid", 32'(rx_if.rx_valid), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_overrun", 32'(overrun), 32'h0);
        chk("t5_frame_err", 32'(frame_err), 32'h0);
        for (int i = 0; i < 6; i++) step();
        chk("t5_no_partial_valid", 32'(rx_if.rx_valid), 32'h0);
        chk("t5_no_partial_busy", 32'(busy), 32'h0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("t5_word", 32'(rx_if.rx_data), 32'h5A);
        chk("t5_word_valid", 32'(rx_if.rx_valid), 32'h1);
        step();
        step();

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
